// File: rtl/pio_edge_capture.sv
// pio_edge_capture: synchronised, glitch-filtered parallel input port with
// per-bit edge capture, interrupt masking and a saturating event counter,
// accessed over a simple Avalon-MM slave with registered read data.
module pio_edge_capture #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int EDGE_TYPE     = 0,
    parameter int FILTER_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [7:0]  FILT_MAX = 8'(FILTER_CYCLES);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_w;

    logic [WIDTH-1:0]        filt_q, filt_d;
    logic [WIDTH-1:0][7:0]   fcnt_q, fcnt_d;

    logic [WIDTH-1:0]        rise_w, fall_w, event_w;
    logic                    any_event_w;

    logic [WIDTH-1:0]        edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0]        irq_mask_q, irq_mask_d;
    logic [15:0]             event_cnt_q, event_cnt_d;
    logic [31:0]             readdata_q, readdata_d;

    logic                    wr_en;
    logic                    wr_mask, wr_cap, wr_cnt;

    // Only writedata[WIDTH-1:0] is meaningful; the remaining bits are don't-care.
    logic                    unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr_en   = chipselect & ~write_n;
    assign wr_mask = wr_en && (address == 3'd2);
    assign wr_cap  = wr_en && (address == 3'd3);
    assign wr_cnt  = wr_en && (address == 3'd4);

    assign sync_w  = sync_q[SYNC_STAGES-1];

    // Synchroniser shift chain; stage 0 samples the raw asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    // Glitch filter: filt follows sync only after FILTER_CYCLES+1 consecutive disagreeing edges.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_w[i] == filt_q[i]) begin
                fcnt_d[i] = 8'd0;
            end else if (fcnt_q[i] == FILT_MAX) begin
                filt_d[i] = sync_w[i];
                fcnt_d[i] = 8'd0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + 8'd1;
            end
        end
    end

    // An event is the edge at which filt changes, qualified by the configured polarity.
    assign rise_w      = filt_d & ~filt_q;
    assign fall_w      = ~filt_d & filt_q;
    assign event_w     = (EDGE_TYPE == 0) ? rise_w :
                         (EDGE_TYPE == 1) ? fall_w : (rise_w | fall_w);
    assign any_event_w = |event_w;

    // Register next-state: capture set beats W1C, counter clear beats increment.
    always_comb begin
        edge_cap_d = (edge_cap_q & ~(wr_cap ? writedata[WIDTH-1:0] : {WIDTH{1'b0}})) | event_w;
        irq_mask_d = wr_mask ? writedata[WIDTH-1:0] : irq_mask_q;
        if (wr_cnt) begin
            event_cnt_d = {15'd0, any_event_w};
        end else if (any_event_w && (event_cnt_q != CNT_MAX)) begin
            event_cnt_d = event_cnt_q + 16'd1;
        end else begin
            event_cnt_d = event_cnt_q;
        end
    end

    // Read mux, registered unconditionally every clock.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            3'd0: readdata_d[WIDTH-1:0] = filt_q;
            3'd2: readdata_d[WIDTH-1:0] = irq_mask_q;
            3'd3: readdata_d[WIDTH-1:0] = edge_cap_q;
            3'd4: readdata_d[15:0]      = event_cnt_q;
            3'd5: begin
                readdata_d[7:0]   = 8'(WIDTH);
                readdata_d[10:8]  = 3'(SYNC_STAGES);
                readdata_d[13:12] = 2'(EDGE_TYPE);
            end
            default: readdata_d = 32'd0;
        endcase
    end

    // State registers; filt starts low so inputs held high through reset raise an event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q      <= '0;
            fcnt_q      <= '0;
            edge_cap_q  <= '0;
            irq_mask_q  <= '0;
            event_cnt_q <= 16'd0;
            readdata_q  <= 32'd0;
        end else begin
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            edge_cap_q  <= edge_cap_d;
            irq_mask_q  <= irq_mask_d;
            event_cnt_q <= event_cnt_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: doc/pio_edge_capture.md
PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

Interface
REQ-001 Parameter WIDTH, default 8, number of input channels, legal 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flops per channel, legal 2..4.
REQ-003 Parameter EDGE_TYPE, default 0, capture mode: 0 rising, 1 falling, 2 any edge.
REQ-004 Parameter FILTER_CYCLES, default 0, glitch-filter length per channel, legal 0..255.
REQ-005 Port clk  input  1  system clock; all state rises on posedge clk.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port address  input  3  Avalon-MM word address.
REQ-008 Port chipselect  input  1  slave select.
REQ-009 Port write_n  input  1  active-low write strobe; write = chipselect & ~write_n.
REQ-010 Port writedata  input  32  write data.
REQ-011 Port in_port  input  WIDTH  asynchronous external inputs.
REQ-012 Port readdata  output  32  registered read data.
REQ-013 Port irq  output  1  level interrupt request.

Function
REQ-014 Each in_port bit SHALL pass through SYNC_STAGES flops; the last stage is sync[i].
REQ-015 Per channel, a filtered value filt[i] and a counter 0..FILTER_CYCLES SHALL exist; the counter clears whenever sync[i]==filt[i].
REQ-016 filt[i] SHALL take sync[i] on the (FILTER_CYCLES+1)th consecutive edge with sync[i]!=filt[i], the counter then clearing; FILTER_CYCLES=0 gives update on the first such edge.
REQ-017 An event on bit i SHALL be the clock edge at which filt[i] changes, qualified by EDGE_TYPE (0: 0->1, 1: 1->0, 2: either).
REQ-018 edge_capture[i] SHALL set on the same edge as its event and hold until cleared.
REQ-019 Write to address 3 SHALL clear each edge_capture bit whose writedata bit is 1 (write-1-to-clear); 0 bits unchanged.
REQ-020 Event and W1C on the same bit in the same cycle: set SHALL win.
REQ-021 Write to address 2 SHALL load irq_mask with writedata[WIDTH-1:0].
REQ-022 irq SHALL be combinational OR of (edge_capture & irq_mask).
REQ-023 event_count (16 bit) SHALL increment by 1 on each edge with at least one event (any bit, multiple bits count once), saturating at 0xFFFF.
REQ-024 Any write to address 4 SHALL clear event_count; simultaneous event SHALL yield 1.
REQ-025 Read map: 0 filt, 2 irq_mask, 3 edge_capture, 4 event_count, 5 {WIDTH,SYNC_STAGES,EDGE_TYPE} as {16'hWIDTH... } packed [7:0]=WIDTH,[10:8]=SYNC_STAGES,[13:12]=EDGE_TYPE; others 0.
REQ-026 readdata SHALL register the read mux every clock (no chipselect qualification), 1-cycle latency; bits above WIDTH and unused bits read 0.
REQ-027 Writes to addresses 0,1,5,6,7 SHALL have no effect.
REQ-028 Default-parameter latency: in_port change before edge N -> edge_capture/irq valid after edge N+2+FILTER_CYCLES.

Reset
REQ-029 reset_n low SHALL asynchronously clear synchronisers, filt, filter counters, edge_capture, irq_mask, event_count, readdata; irq thus 0.
REQ-030 An input held high through reset SHALL generate a rising event after release (filt starts at 0).
REQ-031 Reset asserted mid-filter SHALL discard the count; no event generated from pre-reset activity.

Verification
REQ-032 Defaults, irq_mask=0x01, in_port[0] 0->1 -> edge_capture=0x01 and irq=1 after 3 edges; event_count=1.
REQ-033 FILTER_CYCLES=4, 3-cycle pulse on in_port[2] -> no filt change, edge_capture=0; 6-cycle pulse -> one capture bit 2.
REQ-034 EDGE_TYPE=1, bit 5 rises then falls -> only fall sets edge_capture[5]; EDGE_TYPE=2 -> both set, event_count=2.
REQ-035 Write 0x01 to address 3 in same cycle as new event on bit 0 and bit 1 already set -> bits 0 and 1 remain set; next write 0x03 clears both, irq=0.
REQ-036 Force 0xFFFF events -> event_count holds 0xFFFF; write address 4 -> reads 0; read address 5 with defaults -> 0x00000208.
REQ-037 in_port=0xFF during reset, release -> edge_capture=0xFF after 3 edges; reset mid-filter -> all registers 0, readdata 0.
